fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Read side of the oscilloscope's double-buffered 1-bit framebuffer.
- Generates 640x480@60 raster timing on the pixel clock and issues sequential BRAM read addresses to the display bank.
- Aligns the BRAM bit with DE/syncs and expands it to a 24-bit RGB pixel for the HDMI encoder.
- Owns bank ownership: swaps display/draw banks at vsync start on request from the drawing FSM.

Parameters:
ADDR_WIDTH, 19, framebuffer address width
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_TOTAL, 800, pixels per line incl. blanking
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_TOTAL, 525, lines per frame
FG_COLOR, 24'h00FF00, pixel value for a set bit (background 24'h000000)

Ports:
clk  in  1  pixel clock (25 MHz)
rst  in  1  asynchronous, active-low reset
en  in  1  scan enable
frame_done  in  1  one-cycle pulse from drawing FSM: draw bank complete
DO0  in  1  BRAM bank 0 read data (1-cycle synchronous read)
DO1  in  1  BRAM bank 1 read data
addrRD  out  ADDR_WIDTH  read address to display bank
rd_bank  out  1  bank being displayed; draw bank = ~rd_bank
swap  out  1  one-cycle pulse when banks exchange
frame_drop  out  1  one-cycle pulse: frame_done arrived while a swap was already pending
VDEn  out  1  active video, aligned to pixel
hSync  out  1  active-high hsync, aligned
vSync  out  1  active-high vsync, aligned
pixel  out  24  RGB, aligned

Behaviour:
- Reset (rst=0, async): counterX/counterY=0, addrRD=0, rd_bank=0, pending=0, swap=0, frame_drop=0, VDEn=0, hSync=0, vSync=0, pixel=0.
- Stage 0 counters:
  - counterX wraps H_TOTAL-1 -> 0.
  - counterY increments on X wrap and wraps V_TOTAL-1 -> 0.
  - act0 = X<H_ACTIVE && Y<V_ACTIVE.
  - hs0 = H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC; vs0 likewise with the V parameters.
- Address generator (no multiplier):
  - Registered linear counter; addrRD = value for the current act0 cycle, available at cycle t+1.
  - Increments after each act0 cycle.
  - Cleared to 0 when X=H_TOTAL-1 && Y=V_TOTAL-1, so the first active pixel of every frame reads 0.
  - Last active pixel reads H_ACTIVE*V_ACTIVE-1 (307199).
- Pipeline:
  - t: stage 0.
  - t+1: addrRD presented.
  - t+2: DO valid; select DO0 if rd_bank=0, else DO1.
  - t+3: outputs registered.
  - Fixed latency 3 from stage 0: act/hs/vs go through a 3-deep shift register.
  - pixel = FG_COLOR if the selected bit is 1 and delayed act=1, else 0. VDEn = delayed act.
- Bank select used at t+2 is the rd_bank value captured at t, so a swap never splits a pixel.
- Swap handshake:
  - frame_done sets pending.
  - Swap event = stage 0 at X=0, Y=V_ACTIVE+V_FP (vsync start).
  - At the swap event with pending (or frame_done in the same cycle): rd_bank toggles, pending clears, swap=1 for one cycle.
  - With no request, rd_bank is held and the same frame is re-displayed.
- frame_done while pending=1 (not on a swap cycle): pending stays 1 and frame_drop pulses for 1 cycle.
- en=0:
  - Counters, address and pipeline are held cleared; outputs are blanked (VDEn/hSync/vSync=0, pixel=0).
  - pending and rd_bank are retained; swap does not fire.
  - After en rises, stage 0 starts at (0,0) on the next clock.
- en falling mid-line: blanking reaches the outputs within 3 cycles; partial frame abandoned.

Test Plan:
1. Reset release, en=1, DO0=DO1=0 -> hSync high for exactly 96 clks starting 3 clks after X=656; vSync high for 2 lines (Y=490,491, +3 clk offset); 307200 VDEn cycles/frame; pixel=0 throughout.
2. Bank 0 model holds bit 1 only at addr 0 and 307199 -> pixel=24'h00FF00 on the first and last VDEn cycles of the frame only; addrRD sequence 0..307199 gapless across lines.
3. frame_done pulse at Y=100 -> swap pulse and rd_bank 0->1 at stage-0 (X=0, Y=490); the next frame's pixels come from DO1.
4. frame_done exactly on the swap-event cycle -> swap occurs that cycle, pending=0 afterward; no frame_drop.
5. Two frame_done pulses in one frame -> one frame_drop pulse on the second; exactly one swap at vsync.
6. Assert rst mid-line (X=300, Y=200) asynchronously -> all outputs 0 immediately; after release, first VDEn occurs 3 clks after counters restart at (0,0) with addrRD=0, rd_bank=0.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Signal bundle between the framebuffer scanout block and its surroundings:
// scan control, BRAM read path, bank handshake and the aligned video outputs.
interface fb_scanout_if #(
    parameter int ADDR_WIDTH = 19
) ();
    logic                  en;
    logic                  frame_done;
    logic                  DO0;
    logic                  DO1;
    logic [ADDR_WIDTH-1:0] addrRD;
    logic                  rd_bank;
    logic                  swap;
    logic                  frame_drop;
    logic                  VDEn;
    logic                  hSync;
    logic                  vSync;
    logic [23:0]           pixel;

    modport master (
        output en, frame_done, DO0, DO1,
        input  addrRD, rd_bank, swap, frame_drop, VDEn, hSync, vSync, pixel
    );

    modport slave (
        input  en, frame_done, DO0, DO1,
        output addrRD, rd_bank, swap, frame_drop, VDEn, hSync, vSync, pixel
    );
endinterface

// File: rtl/fb_scanout.sv
// Read side of a double-buffered 1-bit framebuffer: raster timing, linear BRAM
// addressing, 3-cycle aligned RGB output and display/draw bank ownership.
module fb_scanout #(
    parameter int          ADDR_WIDTH = 19,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_TOTAL    = 800,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_TOTAL    = 525,
    parameter logic [23:0] FG_COLOR   = 24'h00FF00
) (
    input logic         clk,
    input logic         rst,
    fb_scanout_if.slave bus
);
    localparam int XW = $clog2(H_TOTAL + 1);
    localparam int YW = $clog2(V_TOTAL + 1);

    localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_HSB  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HSE  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);

    localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_VSB  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VSE  = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [23:0]           BG     = 24'h000000;

    logic [XW-1:0]         cnt_x_q, cnt_x_d;
    logic [YW-1:0]         cnt_y_q, cnt_y_d;
    logic [ADDR_WIDTH-1:0] lin_q, lin_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  pending_q, pending_d;
    logic                  swap_q, swap_d;
    logic                  drop_q, drop_d;
    // Pipe fields: {bank, vs, hs, act}
    logic [3:0]            pipe1_q, pipe1_d;
    logic [3:0]            pipe2_q, pipe2_d;
    logic                  vden_q, vden_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic [23:0]           pixel_q, pixel_d;

    logic act0_s, hs0_s, vs0_s, x_wrap_s, frame_end_s, swap_ev_s, swap_req_s, bit_s;

    // Stage-0 raster decode from the current counter position.
    always_comb begin
        act0_s      = bus.en && (cnt_x_q < X_ACT) && (cnt_y_q < Y_ACT);
        hs0_s       = bus.en && (cnt_x_q >= X_HSB) && (cnt_x_q < X_HSE);
        vs0_s       = bus.en && (cnt_y_q >= Y_VSB) && (cnt_y_q < Y_VSE);
        x_wrap_s    = (cnt_x_q == X_LAST);
        frame_end_s = x_wrap_s && (cnt_y_q == Y_LAST);
        swap_ev_s   = bus.en && (cnt_x_q == X_ZERO) && (cnt_y_q == Y_VSB);
        swap_req_s  = pending_q || bus.frame_done;
        bit_s       = pipe2_q[3] ? bus.DO1 : bus.DO0;
    end

    // Counters, address generator and the 3-deep alignment pipeline.
    always_comb begin
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        lin_d   = lin_q;
        addr_d  = addr_q;
        pipe1_d = pipe1_q;
        pipe2_d = pipe2_q;
        vden_d  = vden_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        pixel_d = pixel_q;
        if (bus.en) begin
            if (x_wrap_s) begin
                cnt_x_d = X_ZERO;
                cnt_y_d = (cnt_y_q == Y_LAST) ? Y_ZERO : (cnt_y_q + Y_ONE);
            end else begin
                cnt_x_d = cnt_x_q + X_ONE;
            end
            // Restart at the very last blanking pixel so each frame begins at 0.
            if (frame_end_s) begin
                lin_d = A_ZERO;
            end else if (act0_s) begin
                lin_d = lin_q + A_ONE;
            end else begin
                lin_d = lin_q;
            end
            addr_d  = act0_s ? lin_q : addr_q;
            pipe1_d = {rd_bank_q, vs0_s, hs0_s, act0_s};
            pipe2_d = pipe1_q;
            vden_d  = pipe2_q[0];
            hsync_d = pipe2_q[1];
            vsync_d = pipe2_q[2];
            pixel_d = (pipe2_q[0] && bit_s) ? FG_COLOR : BG;
        end else begin
            cnt_x_d = X_ZERO;
            cnt_y_d = Y_ZERO;
            lin_d   = A_ZERO;
            addr_d  = A_ZERO;
            pipe1_d = 4'b0000;
            pipe2_d = 4'b0000;
            vden_d  = 1'b0;
            hsync_d = 1'b0;
            vsync_d = 1'b0;
            pixel_d = BG;
        end
    end

    // Bank ownership: swap at vsync start when the drawing side has finished.
    always_comb begin
        rd_bank_d = rd_bank_q;
        pending_d = pending_q;
        swap_d    = 1'b0;
        drop_d    = 1'b0;
        if (swap_ev_s && swap_req_s) begin
            rd_bank_d = ~rd_bank_q;
            pending_d = 1'b0;
            swap_d    = 1'b1;
        end else if (bus.frame_done) begin
            pending_d = 1'b1;
            drop_d    = pending_q;
        end else begin
            pending_d = pending_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_x_q   <= X_ZERO;
            cnt_y_q   <= Y_ZERO;
            lin_q     <= A_ZERO;
            addr_q    <= A_ZERO;
            rd_bank_q <= 1'b0;
            pending_q <= 1'b0;
            swap_q    <= 1'b0;
            drop_q    <= 1'b0;
            pipe1_q   <= 4'b0000;
            pipe2_q   <= 4'b0000;
            vden_q    <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            pixel_q   <= BG;
        end else begin
            cnt_x_q   <= cnt_x_d;
            cnt_y_q   <= cnt_y_d;
            lin_q     <= lin_d;
            addr_q    <= addr_d;
            rd_bank_q <= rd_bank_d;
            pending_q <= pending_d;
            swap_q    <= swap_d;
            drop_q    <= drop_d;
            pipe1_q   <= pipe1_d;
            pipe2_q   <= pipe2_d;
            vden_q    <= vden_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            pixel_q   <= pixel_d;
        end
    end

    assign bus.addrRD     = addr_q;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.swap       = swap_q;
    assign bus.frame_drop = drop_q;
    assign bus.VDEn       = vden_q;
    assign bus.hSync      = hsync_q;
    assign bus.vSync      = vsync_q;
    assign bus.pixel      = pixel_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a reduced 16x12 raster (8x6 visible, 48 pixels),
// with two small BRAM bank models behind the read address.
module tb_fb_scanout;
    localparam logic [23:0] FG = 24'h00FF00;
    localparam logic [23:0] Z  = 24'h000000;
    localparam int          N  = 780;

    typedef struct {
        int          cyc;
        logic        vden;
        logic        hs;
        logic        vs;
        logic [23:0] pix;
        logic [18:0] addr;
        logic        bank;
        logic        swp;
        logic        drop;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic        mem0 [0:63];
    logic        mem1 [0:63];
    logic        rec_vden [0:N];
    logic        rec_hs   [0:N];
    logic        rec_vs   [0:N];
    logic [23:0] rec_pix  [0:N];
    logic [18:0] rec_addr [0:N];
    logic        rec_bank [0:N];
    logic        rec_swp  [0:N];
    logic        rec_drop [0:N];
    vec_t        vecs[$];

    fb_scanout_if #(.ADDR_WIDTH(19)) bus ();

    fb_scanout #(
        .ADDR_WIDTH(19), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_TOTAL(16),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_TOTAL(12), .FG_COLOR(24'h00FF00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read BRAM models, one cycle from address to data.
    always @(posedge clk) begin
        bus.DO0 <= mem0[bus.addrRD[5:0]];
        bus.DO1 <= mem1[bus.addrRD[5:0]];
    end

    function automatic logic [63:0] mkp(logic v, logic h, logic s, logic [23:0] p,
                                        logic [18:0] a, logic b, logic w, logic d);
        return {15'd0, v, h, s, p, a, b, w, d};
    endfunction

    function automatic logic [63:0] cur();
        return mkp(bus.VDEn, bus.hSync, bus.vSync, bus.pixel, bus.addrRD,
                   bus.rd_bank, bus.swap, bus.frame_drop);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    initial begin
        int n_vden, n_hs, n_vs, n_fg, n_swp, n_drop, n_bad, n_step;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 1'b0;
            mem1[i] = i[0];
        end
        mem0[0]  = 1'b1;
        mem0[47] = 1'b1;

        //        cyc  vden  hs    vs    pix  addr    bank  swap  drop
        vecs.push_back('{  1, 1'b0, 1'b0, 1'b0, Z,  19'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{  3, 1'b1, 1'b0, 1'b0, FG, 19'd2,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{  4, 1'b1, 1'b0, 1'b0, Z,  19'd3,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{ 11, 1'b0, 1'b0, 1'b0, Z,  19'd7,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{ 13, 1'b0, 1'b1, 1'b0, Z,  19'd7,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{ 15, 1'b0, 1'b1, 1'b0, Z,  19'd7,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{ 16, 1'b0, 1'b0, 1'b0, Z,  19'd7,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{ 19, 1'b1, 1'b0, 1'b0, Z,  19'd10, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{ 90, 1'b1, 1'b0, 1'b0, FG, 19'd47, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{ 91, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{112, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{113, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{114, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{115, 1'b0, 1'b0, 1'b1, Z,  19'd47, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{146, 1'b0, 1'b0, 1'b1, Z,  19'd47, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{147, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{193, 1'b0, 1'b0, 1'b0, Z,  19'd0,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{195, 1'b1, 1'b0, 1'b0, Z,  19'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{196, 1'b1, 1'b0, 1'b0, FG, 19'd3,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{282, 1'b1, 1'b0, 1'b0, FG, 19'd47, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{304, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{305, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{387, 1'b1, 1'b0, 1'b0, FG, 19'd2,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{417, 1'b0, 1'b0, 1'b0, Z,  19'd16, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{449, 1'b0, 1'b0, 1'b0, Z,  19'd32, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{450, 1'b0, 1'b0, 1'b0, Z,  19'd33, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{497, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{579, 1'b1, 1'b0, 1'b0, Z,  19'd2,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{580, 1'b1, 1'b0, 1'b0, FG, 19'd3,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{689, 1'b0, 1'b0, 1'b0, Z,  19'd47, 1'b1, 1'b0, 1'b0});

        rst            = 1'b0;
        bus.en         = 1'b0;
        bus.frame_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", cur(), 64'd0);

        // Cycle 0 is stage 0 at (0,0); frame_done for cycle c is driven at its negedge.
        bus.en = 1'b1;
        rst    = 1'b1;
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            rec_vden[c] = bus.VDEn;
            rec_hs[c]   = bus.hSync;
            rec_vs[c]   = bus.vSync;
            rec_pix[c]  = bus.pixel;
            rec_addr[c] = bus.addrRD;
            rec_bank[c] = bus.rd_bank;
            rec_swp[c]  = bus.swap;
            rec_drop[c] = bus.frame_drop;
            bus.frame_done = (c == 48) || (c == 304) || (c == 416) || (c == 448);
        end

        foreach (vecs[i]) begin
            int c;
            c = vecs[i].cyc;
            chk($sformatf("vec_c%0d", c),
                mkp(rec_vden[c], rec_hs[c], rec_vs[c], rec_pix[c], rec_addr[c],
                    rec_bank[c], rec_swp[c], rec_drop[c]),
                mkp(vecs[i].vden, vecs[i].hs, vecs[i].vs, vecs[i].pix, vecs[i].addr,
                    vecs[i].bank, vecs[i].swp, vecs[i].drop));
        end

        n_vden = 0; n_hs = 0; n_vs = 0; n_fg = 0; n_swp = 0; n_drop = 0; n_bad = 0; n_step = 0;
        for (int c = 3; c <= 194; c++) begin
            n_vden += int'(rec_vden[c]);
            n_hs   += int'(rec_hs[c]);
            n_vs   += int'(rec_vs[c]);
            n_fg   += int'(rec_pix[c] == FG);
        end
        for (int c = 1; c <= N; c++) begin
            n_swp  += int'(rec_swp[c]);
            n_drop += int'(rec_drop[c]);
        end
        for (int c = 2; c <= N; c++) begin
            if (rec_addr[c] != rec_addr[c-1]) begin
                if (c <= 192) n_step++;
                if (!((rec_addr[c] == rec_addr[c-1] + 19'd1) ||
                      (rec_addr[c] == 19'd0 && rec_addr[c-1] == 19'd47))) n_bad++;
            end
        end
        chk("frame_vden_count",  64'(n_vden), 64'd48);
        chk("frame_hsync_count", 64'(n_hs),   64'd36);
        chk("frame_vsync_count", 64'(n_vs),   64'd32);
        chk("frame_fg_count",    64'(n_fg),   64'd2);
        chk("swap_count",        64'(n_swp),  64'd3);
        chk("drop_count",        64'(n_drop), 64'd1);
        chk("addr_gaps",         64'(n_bad),  64'd0);
        chk("addr_steps_frame0", 64'(n_step), 64'd47);

        // Scan disable mid-frame: blanked and cleared, bank retained.
        @(negedge clk);
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_low_blank", cur(), mkp(1'b0, 1'b0, 1'b0, Z, 19'd0, 1'b1, 1'b0, 1'b0));
        bus.en = 1'b1;
        @(negedge clk);
        chk("en_restart_c1", cur(), mkp(1'b0, 1'b0, 1'b0, Z, 19'd0, 1'b1, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        chk("en_restart_c3", cur(), mkp(1'b1, 1'b0, 1'b0, Z, 19'd2, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        chk("en_restart_c4", cur(), mkp(1'b1, 1'b0, 1'b0, FG, 19'd3, 1'b1, 1'b0, 1'b0));

        // Asynchronous reset in the middle of an active line (stage 0 at x=5, y=2).
        repeat (33) @(negedge clk);
        chk("pre_reset", cur(), mkp(1'b1, 1'b0, 1'b0, Z, 19'd20, 1'b1, 1'b0, 1'b0));
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", cur(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_c1", cur(), mkp(1'b0, 1'b0, 1'b0, Z, 19'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("post_reset_c2", cur(), mkp(1'b0, 1'b0, 1'b0, Z, 19'd1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("post_reset_c3", cur(), mkp(1'b1, 1'b0, 1'b0, FG, 19'd2, 1'b0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
